// File: rtl/ffo_scan_sequencer.sv
// Drains a request word through a single MSB-priority leading-one detector,
// emitting one bit index per output beat from highest to lowest.
module ffo_scan_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic             out_empty,
    output logic [5:0]       out_seq,
    output logic             busy
);
    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mask_q;
    logic [5:0]       seq_q;
    logic             rst_q;
    logic [IDXW-1:0]  ffo_idx;
    logic [WIDTH-1:0] mask_clr;
    logic             mask_last;

    function automatic logic [IDXW-1:0] ffo(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    always_comb begin
        ffo_idx   = ffo(mask_q);
        mask_clr  = mask_q & ~(WIDTH'(1) << ffo_idx);
        mask_last = (mask_clr == '0);
    end

    // rst_q keeps in_ready low while reset is held, without a path from the reset pin.
    assign in_ready  = (state_q == IDLE) && !rst_q;
    assign out_valid = (state_q == SCAN) || (state_q == ZERO);
    assign out_idx   = (state_q == SCAN) ? ffo_idx : 5'd0;
    assign out_last  = ((state_q == SCAN) && mask_last) || (state_q == ZERO);
    assign out_empty = (state_q == ZERO);
    assign out_seq   = seq_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            seq_q   <= '0;
            rst_q   <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (flush) begin
                if (state_q != IDLE) begin
                    state_q <= IDLE;
                    mask_q  <= '0;
                    seq_q   <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            seq_q <= '0;
                            if (in_data != '0) begin
                                mask_q  <= in_data;
                                state_q <= SCAN;
                            end else begin
                                state_q <= ZERO;
                            end
                        end
                    end
                    SCAN: begin
                        if (out_ready) begin
                            mask_q <= mask_clr;
                            seq_q  <= seq_q + 6'd1;
                            if (mask_last) state_q <= IDLE;
                        end
                    end
                    ZERO: begin
                        if (out_ready) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ffo_scan_sequencer.sv
// Directed bench for ffo_scan_sequencer: reset, scan order, backpressure,
// zero word, flush and mid-word reset, with hand-computed expectations.
module tb_ffo_scan_sequencer;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [4:0]  out_idx;
    logic        out_last, out_empty, busy;
    logic [5:0]  out_seq;

    int checks = 0;
    int errors = 0;

    ffo_scan_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_empty(out_empty), .out_seq(out_seq),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_empty"}, 32'(out_empty), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_out_seq"},   32'(out_seq),   32'd0);
    endtask

    task automatic chk_beat(input string tag, input int idx, input int seq, input bit last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
        chk({tag, "_seq"},   32'(out_seq),   32'(seq));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_empty"}, 32'(out_empty), 32'd0);
    endtask

    int exp_idx [6] = '{7, 7, 7, 5, 5, 2};
    int exp_seq [6] = '{0, 0, 0, 1, 1, 2};
    bit exp_last[6] = '{0, 0, 0, 0, 0, 1};
    bit rdy_pat [6] = '{0, 0, 1, 0, 1, 1};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Two-bit word at both extremes
        in_valid = 1'b1; in_data = 32'h8000_0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("w1_b0", 31, 0, 1'b0);
        chk("w1_in_ready_busy", 32'(in_ready), 32'd0);
        chk("w1_busy", 32'(busy), 32'd1);
        step();
        chk_beat("w1_b1", 0, 1, 1'b1);
        step();
        chk("w1_done_in_ready", 32'(in_ready), 32'd1);
        chk("w1_done_valid", 32'(out_valid), 32'd0);

        // All-zero word: a single empty-flagged beat
        in_valid = 1'b1; in_data = 32'h0;
        step();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_idx",   32'(out_idx),   32'd0);
        chk("zero_empty", 32'(out_empty), 32'd1);
        chk("zero_last",  32'(out_last),  32'd1);
        chk("zero_seq",   32'(out_seq),   32'd0);
        chk("zero_busy",  32'(busy),      32'd1);
        step();
        chk("zero_done_busy",  32'(busy),     32'd0);
        chk("zero_done_ready", 32'(in_ready), 32'd1);

        // Full word; a pending word must not be taken mid-scan
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        step();
        in_data = 32'h0000_0005;
        for (int i = 0; i < 32; i++) begin
            chk_beat($sformatf("full_b%0d", i), 31 - i, i, (i == 31));
            chk($sformatf("full_in_ready%0d", i), 32'(in_ready), 32'd0);
            if (i == 31) in_valid = 1'b0;
            step();
        end
        chk("full_done_valid", 32'(out_valid), 32'd0);
        chk("full_done_ready", 32'(in_ready),  32'd1);

        // Backpressure: beats hold while out_ready is low
        in_valid = 1'b1; in_data = 32'h0000_00A4; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            out_ready = rdy_pat[c];
            chk_beat($sformatf("bp_c%0d", c), exp_idx[c], exp_seq[c], exp_last[c]);
            step();
        end
        chk("bp_done_valid", 32'(out_valid), 32'd0);

        // Flush mid-word, then flush in IDLE blocks a handshake
        in_valid = 1'b1; in_data = 32'h0F00_0000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("fl_b0", 27, 0, 1'b0);
        step();
        chk_beat("fl_b1", 26, 1, 1'b0);
        out_ready = 1'b0; flush = 1'b1;
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_busy",  32'(busy),      32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b1; in_data = 32'h0000_0002;
        step();
        chk("fl_idle_blocks_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("fl_next", 1, 0, 1'b1);
        step();
        chk("fl_next_done", 32'(out_valid), 32'd0);

        // Reset mid-word
        in_valid = 1'b1; in_data = 32'h0000_F000;
        step();
        in_valid = 1'b0;
        chk_beat("mr_b0", 15, 0, 1'b0);
        step();
        chk_beat("mr_b1", 14, 1, 1'b0);
        reset = 1'b1;
        step();
        chk_reset_vals("mr");
        reset = 1'b0;
        step();
        chk("mr_release_ready", 32'(in_ready),  32'd1);
        chk("mr_release_valid", 32'(out_valid), 32'd0);
        step();
        chk("mr_no_residual", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
